romarb: RTL

Arbiter between the mapper's two ROM fetch ports (PRG via `prom*`, CHR via `crom*`) and the single external ROM memory port. Merges both req/ack streams onto one port: PRG in the lower half of ROM space, CHR in the upper half. Keeps a one-entry last-byte cache per port so repeated fetches of the same address skip the external memory. Sits directly downstream of the mapper and upstream of the memory controller.

---
 rtl/romarb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/romarb.sv
// romarb: arbiter between the mapper's PRG and CHR ROM fetch ports and the
// single external ROM memory port. PRG maps to the lower half of ROM space,
// CHR to the upper half. Each port keeps a one-entry last-byte cache so a
// repeated fetch of the same address is answered without a memory access.
//
// Ports:
//   clk, rst               system clock, asynchronous active-high reset
//   promaddr/promreq       PRG fetch request (level, held until promack)
//   promack/promdata       PRG one-cycle completion pulse and held read data
//   cromaddr/cromreq       CHR fetch request (level, held until cromack)
//   cromack/cromdata       CHR one-cycle completion pulse and held read data
//   flush                  one-cycle pulse invalidating both cache entries
//   maddr/mreq             external request, {port, address}, held until mack
//   mack/mrdata            external completion pulse with same-cycle data
module romarb #(
   parameter int unsigned CACHE = 1,
   localparam int unsigned AW = 21,
   localparam int unsigned DW = 8,
   localparam int unsigned MW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] promaddr,
   input  logic          promreq,
   output logic          promack,
   output logic [DW-1:0] promdata,
   input  logic [AW-1:0] cromaddr,
   input  logic          cromreq,
   output logic          cromack,
   output logic [DW-1:0] cromdata,
   input  logic          flush,
   output logic [MW-1:0] maddr,
   output logic          mreq,
   input  logic          mack,
   input  logic [DW-1:0] mrdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_d;

   // Port encoding throughout: 0 = PRG, 1 = CHR.
   logic                 last, last_d;
   logic                 gport, gport_d;
   logic [AW-1:0]        gaddr, gaddr_d;

   // One-entry cache per port.
   logic [1:0]           valid, valid_d;
   logic [1:0][AW-1:0]   tag, tag_d;
   logic [1:0][DW-1:0]   cdat, cdat_d;

   logic                 promack_d, cromack_d;
   logic [DW-1:0]        promdata_d, cromdata_d;
   logic                 mreq_d;
   logic [MW-1:0]        maddr_d;

   logic                 peli_c, celi_c, sel_c, hit_c;
   logic [AW-1:0]        saddr_c;
   logic                 rsp_c, rport_c;
   logic [DW-1:0]        rdata_c;

   // Next-state, grant, cache lookup/fill and response generation.
   always_comb begin
      state_d    = state;
      last_d     = last;
      gport_d    = gport;
      gaddr_d    = gaddr;
      valid_d    = flush ? 2'b00 : valid;
      tag_d      = tag;
      cdat_d     = cdat;
      promack_d  = 1'b0;
      cromack_d  = 1'b0;
      promdata_d = promdata;
      cromdata_d = cromdata;
      mreq_d     = mreq;
      maddr_d    = maddr;
      rsp_c      = 1'b0;
      rport_c    = gport;
      rdata_c    = '0;

      // A req seen during its own ack cycle is the tail of the finished request.
      peli_c  = promreq & ~promack;
      celi_c  = cromreq & ~cromack;
      // On contention pick the port opposite the last contended grant.
      sel_c   = (peli_c & celi_c) ? ~last : celi_c;
      saddr_c = sel_c ? cromaddr : promaddr;
      // A flush in the lookup cycle already counts as invalidating the entry.
      hit_c   = (CACHE != 0) && valid[sel_c] && (tag[sel_c] == saddr_c) && !flush;

      unique case (state)
         IDLE: begin
            if (peli_c | celi_c) begin
               if (peli_c & celi_c) last_d = sel_c;
               gport_d = sel_c;
               gaddr_d = saddr_c;
               if (hit_c) begin
                  rsp_c   = 1'b1;
                  rport_c = sel_c;
                  rdata_c = cdat[sel_c];
               end else begin
                  state_d = MEM;
                  mreq_d  = 1'b1;
                  maddr_d = {sel_c, saddr_c};
               end
            end
         end
         MEM: begin
            if (mack) begin
               mreq_d  = 1'b0;
               rsp_c   = 1'b1;
               rport_c = gport;
               rdata_c = mrdata;
               // The fill is written even if a flush arrived while waiting.
               if (CACHE != 0) begin
                  valid_d[gport] = 1'b1;
                  tag_d[gport]   = gaddr;
                  cdat_d[gport]  = mrdata;
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Both hit and fill paths converge here: one-cycle ack plus data update.
      if (rsp_c) begin
         state_d = RESP;
         if (rport_c) begin
            cromack_d  = 1'b1;
            cromdata_d = rdata_c;
         end else begin
            promack_d  = 1'b1;
            promdata_d = rdata_c;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         gport    <= 1'b0;
         gaddr    <= '0;
         valid    <= 2'b00;
         tag      <= '0;
         cdat     <= '0;
         promack  <= 1'b0;
         cromack  <= 1'b0;
         promdata <= '0;
         cromdata <= '0;
         mreq     <= 1'b0;
         maddr    <= '0;
      end else begin
         state    <= state_d;
         last     <= last_d;
         gport    <= gport_d;
         gaddr    <= gaddr_d;
         valid    <= valid_d;
         tag      <= tag_d;
         cdat     <= cdat_d;
         promack  <= promack_d;
         cromack  <= cromack_d;
         promdata <= promdata_d;
         cromdata <= cromdata_d;
         mreq     <= mreq_d;
         maddr    <= maddr_d;
      end
   end

endmodule
